// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory port arbiter.
package mem_arb_pkg;

    localparam int unsigned DEF_AW      = 32;
    localparam int unsigned DEF_DW      = 32;
    localparam int unsigned DEF_MEM_LAT = 1;
    localparam int unsigned CNT_W       = 4;
    localparam int unsigned STATS_W     = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    localparam logic SEL_I = 1'b0;
    localparam logic SEL_D = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin grant; last_grant only advances when upd is high.
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic req_i,
    input  logic req_d,
    input  logic upd,
    output logic grant_c,
    output logic sel_c
);

    logic last_grant;

    always_comb begin
        grant_c = req_i | req_d;
        sel_c   = SEL_I;
        if (req_i && req_d) begin
            sel_c = ~last_grant;
        end else if (req_d) begin
            sel_c = SEL_D;
        end
    end

    // Reset to D so that I wins the first conflict.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_grant <= SEL_D;
        end else if (upd) begin
            last_grant <= sel_c;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency single-port memory between fetch (I) and load/store (D).
// Optional ARB_STATS_EN adds a saturating conflict counter output.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned AW      = DEF_AW,
    parameter int unsigned DW      = DEF_DW,
    parameter int unsigned MEM_LAT = DEF_MEM_LAT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic [DW-1:0] i_rdata,
    output logic          i_ack,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_ack,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
`ifdef ARB_STATS_EN
    ,
    output logic [STATS_W-1:0] conflicts
`endif
);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             lat_sel;
    logic             lat_we;
    logic             grant_c;
    logic             sel_c;
    logic             conflict_c;

    assign conflict_c = (state == ST_IDLE) && i_req && d_req;

    rr_arb2 u_rr (
        .clk     (clk),
        .rst     (rst),
        .req_i   (i_req),
        .req_d   (d_req),
        .upd     (conflict_c),
        .grant_c (grant_c),
        .sel_c   (sel_c)
    );

    // Access sequencer; mem_* registers double as the latched request.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            lat_sel   <= SEL_I;
            lat_we    <= 1'b0;
            i_rdata   <= '0;
            d_rdata   <= '0;
            i_ack     <= 1'b0;
            d_ack     <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            busy      <= 1'b0;
        end else begin
            i_ack <= 1'b0;
            d_ack <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (grant_c) begin
                        lat_sel <= sel_c;
                        mem_en  <= 1'b1;
                        busy    <= 1'b1;
                        state   <= ST_ACCESS;
                        if (sel_c == SEL_D) begin
                            lat_we    <= d_we;
                            mem_we    <= d_we;
                            mem_addr  <= d_addr;
                            mem_wdata <= d_wdata;
                        end else begin
                            lat_we    <= 1'b0;
                            mem_we    <= 1'b0;
                            mem_addr  <= i_addr;
                            mem_wdata <= '0;
                        end
                    end
                end
                ST_ACCESS: begin
                    mem_en    <= 1'b0;
                    mem_we    <= 1'b0;
                    mem_addr  <= '0;
                    mem_wdata <= '0;
                    cnt       <= CNT_W'(MEM_LAT);
                    state     <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (cnt == CNT_W'(1)) begin
                        if (!lat_we) begin
                            if (lat_sel == SEL_D) d_rdata <= mem_rdata;
                            else                  i_rdata <= mem_rdata;
                        end
                        if (lat_sel == SEL_D) d_ack <= 1'b1;
                        else                  i_ack <= 1'b1;
                        cnt   <= '0;
                        state <= ST_RESP;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef ARB_STATS_EN
    // Saturating count of IDLE cycles where both ports requested.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            conflicts <= '0;
        end else if (conflict_c && (conflicts != {STATS_W{1'b1}})) begin
            conflicts <= conflicts + STATS_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter at MEM_LAT=1 and MEM_LAT=3.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    logic        i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [31:0] i_addr = '0, d_addr = '0, d_wdata = '0;
    logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        i_ack, d_ack, mem_en, mem_we, busy;

    logic        k_req = 1'b0;
    logic [31:0] k_addr = '0;
    logic [31:0] k_i_rdata, k_d_rdata, k_mem_addr, k_mem_wdata, k_mem_rdata;
    logic        k_i_ack, k_d_ack, k_mem_en, k_mem_we, k_busy;

`ifdef ARB_STATS_EN
    logic [15:0] conflicts, k_conflicts;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(1)) u0 (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ack(d_ack),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
`ifdef ARB_STATS_EN
        , .conflicts(conflicts)
`endif
    );

    mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(3)) u3 (
        .clk(clk), .rst(rst),
        .i_req(k_req), .i_addr(k_addr), .i_rdata(k_i_rdata), .i_ack(k_i_ack),
        .d_req(1'b0), .d_we(1'b0), .d_addr(32'h0), .d_wdata(32'h0),
        .d_rdata(k_d_rdata), .d_ack(k_d_ack),
        .mem_en(k_mem_en), .mem_we(k_mem_we), .mem_addr(k_mem_addr),
        .mem_wdata(k_mem_wdata), .mem_rdata(k_mem_rdata), .busy(k_busy)
`ifdef ARB_STATS_EN
        , .conflicts(k_conflicts)
`endif
    );

    // Memory models: data = addr ^ DEAD_BEFF only exactly MEM_LAT cycles after mem_en.
    logic [3:0]  age0 = '0, age3 = '0;
    logic [31:0] maddr0 = '0, maddr3 = '0;

    always @(posedge clk) begin
        if (mem_en) begin
            age0   <= 4'd1;
            maddr0 <= mem_addr;
        end else if (age0 != 4'd0 && age0 != 4'd15) begin
            age0 <= age0 + 4'd1;
        end
        if (k_mem_en) begin
            age3   <= 4'd1;
            maddr3 <= k_mem_addr;
        end else if (age3 != 4'd0 && age3 != 4'd15) begin
            age3 <= age3 + 4'd1;
        end
    end

    assign mem_rdata   = (age0 == 4'd1) ? (maddr0 ^ 32'hDEAD_BEFF) : 32'h0BAD_0BAD;
    assign k_mem_rdata = (age3 == 4'd3) ? (maddr3 ^ 32'hDEAD_BEFF) : 32'h0BAD_0BAD;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        int ack_cyc;
        int pulses;

        // Reset state
        step();
        chk("rst_busy",    32'(busy), 32'h0);
        chk("rst_mem_en",  32'(mem_en), 32'h0);
        chk("rst_i_ack",   32'(i_ack), 32'h0);
        chk("rst_i_rdata", i_rdata, 32'h0);
        chk("rst_d_rdata", d_rdata, 32'h0);
        chk("rst_k_busy",  32'(k_busy), 32'h0);
        rst = 1'b1;
        step();

        // Single fetch
        i_req = 1'b1; i_addr = 32'h0000_0010;
        step();
        chk("f_mem_en",   32'(mem_en), 32'h1);
        chk("f_mem_addr", mem_addr, 32'h0000_0010);
        chk("f_mem_we",   32'(mem_we), 32'h0);
        chk("f_busy",     32'(busy), 32'h1);
        i_addr = 32'h0000_0999;
        step();
        chk("f_wait_en",  32'(mem_en), 32'h0);
        chk("f_wait_ack", 32'(i_ack), 32'h0);
        step();
        chk("f_i_ack",    32'(i_ack), 32'h1);
        chk("f_i_rdata",  i_rdata, 32'hDEAD_BEEF);
        chk("f_d_ack",    32'(d_ack), 32'h0);
        i_req = 1'b0;
        step();
        chk("f_idle_busy", 32'(busy), 32'h0);
        chk("f_ack_pulse", 32'(i_ack), 32'h0);
        chk("f_rdata_hold", i_rdata, 32'hDEAD_BEEF);

        // Data write
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'h1234_5678;
        step();
        chk("w_mem_en",    32'(mem_en), 32'h1);
        chk("w_mem_we",    32'(mem_we), 32'h1);
        chk("w_mem_addr",  mem_addr, 32'h40);
        chk("w_mem_wdata", mem_wdata, 32'h1234_5678);
        step();
        chk("w_wait_en",   32'(mem_en), 32'h0);
        step();
        chk("w_d_ack",     32'(d_ack), 32'h1);
        chk("w_d_rdata",   d_rdata, 32'h0);
        d_req = 1'b0; d_we = 1'b0;
        step();
        chk("w_idle_busy", 32'(busy), 32'h0);

        // Data read
        d_req = 1'b1; d_addr = 32'h80;
        step();
        chk("r_mem_we", 32'(mem_we), 32'h0);
        step();
        step();
        chk("r_d_ack",   32'(d_ack), 32'h1);
        chk("r_d_rdata", d_rdata, 32'hDEAD_BE7F);
        chk("r_i_hold",  i_rdata, 32'hDEAD_BEEF);
        d_req = 1'b0;
        step();

        // Early request drop during ACCESS
        i_req = 1'b1; i_addr = 32'h20;
        step();
        i_req = 1'b0;
        step();
        step();
        chk("e_i_ack",   32'(i_ack), 32'h1);
        chk("e_i_rdata", i_rdata, 32'hDEAD_BEDF);
        step();
        chk("e_busy",    32'(busy), 32'h0);
        step();
        chk("e_no_new",  32'(mem_en), 32'h0);

        // Round robin with both requests held
        i_req = 1'b1; i_addr = 32'h100;
        d_req = 1'b1; d_addr = 32'h200; d_we = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step(); step(); step();
            chk($sformatf("rr%0d_i_ack", k), 32'(i_ack), (k % 2 == 0) ? 32'h1 : 32'h0);
            chk($sformatf("rr%0d_d_ack", k), 32'(d_ack), (k % 2 == 1) ? 32'h1 : 32'h0);
            step();
        end
        i_req = 1'b0; d_req = 1'b0;
        chk("rr_i_rdata", i_rdata, 32'hDEAD_BFFF);
        chk("rr_d_rdata", d_rdata, 32'hDEAD_BCFF);
`ifdef ARB_STATS_EN
        chk("rr_conflicts", 32'(conflicts), 32'd4);
`endif
        step();
        chk("rr_idle", 32'(busy), 32'h0);

        // MEM_LAT=3 instance
        k_req = 1'b1; k_addr = 32'h30;
        ack_cyc = -1;
        pulses  = 0;
        for (int c = 1; c <= 10; c++) begin
            step();
            if (k_mem_en) pulses++;
            if (k_i_ack && ack_cyc < 0) begin
                ack_cyc = c;
                k_req   = 1'b0;
            end
        end
        chk("l3_ack_cycle", 32'(ack_cyc), 32'd5);
        chk("l3_pulses",    32'(pulses), 32'd1);
        chk("l3_rdata",     k_i_rdata, 32'hDEAD_BECF);

        // Reset in the middle of WAIT
        i_req = 1'b1; i_addr = 32'h44;
        step();
        step();
        #2 rst = 1'b0;
        #1;
        chk("ra_busy",    32'(busy), 32'h0);
        chk("ra_mem_en",  32'(mem_en), 32'h0);
        chk("ra_i_rdata", i_rdata, 32'h0);
        chk("ra_d_rdata", d_rdata, 32'h0);
        step();
        step();
        chk("ra_no_ack",  32'(i_ack), 32'h0);
        rst = 1'b1;
        d_req = 1'b1; d_addr = 32'h48;
        step();
        chk("ra_grant_i", mem_addr, 32'h44);
        step();
        step();
        chk("ra_i_ack",   32'(i_ack), 32'h1);
        chk("ra_d_ack",   32'(d_ack), 32'h0);
        chk("ra_rdata",   i_rdata, 32'hDEAD_BEBB);
`ifdef ARB_STATS_EN
        chk("ra_conflicts", 32'(conflicts), 32'd1);
`endif
        i_req = 1'b0; d_req = 1'b0;
        step();
        step();
        chk("ra_end_idle", 32'(busy), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Arbitrates one single-port synchronous memory between two requesters: the instruction-fetch path (PC-driven, port I) and the load/store path (port D).
- Sits between the PC/fetch logic and datapath on one side and the shared memory on the other, inside top.
- Sequences each access: grant, memory strobe, fixed-latency wait, response capture, acknowledge.
- Round-robin arbitration when both ports request in the same cycle.

Parameters:
- AW, 32, address width in bits.
- DW, 32, data width in bits.
- MEM_LAT, 1, memory read latency in cycles from mem_en to valid mem_rdata; legal range 1..15.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset (rst=0 resets).
- i_req  in  1  fetch request; held high until i_ack.
- i_addr  in  AW  fetch address; stable while i_req=1.
- i_rdata  out  DW  fetched word; valid while i_ack=1, held afterwards.
- i_ack  out  1  one-cycle completion pulse for port I.
- d_req  in  1  data request; held high until d_ack.
- d_we  in  1  1 = write, 0 = read.
- d_addr  in  AW  data address.
- d_wdata  in  DW  write data.
- d_rdata  out  DW  read word; valid while d_ack=1, held afterwards.
- d_ack  out  1  one-cycle completion pulse for port D.
- mem_en  out  1  memory strobe, exactly one cycle per access.
- mem_we  out  1  memory write enable, qualified by mem_en.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data; valid MEM_LAT cycles after the mem_en cycle.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (rst=0, asynchronous):
  - State = IDLE.
  - All outputs 0; i_rdata and d_rdata = 0.
  - Wait counter = 0.
  - last_grant = D, so I wins the first conflict.
- States: IDLE -> ACCESS -> WAIT -> RESP -> IDLE.
- IDLE:
  - No request: stay in IDLE.
  - Exactly one request: grant it.
  - Both requests: grant the port other than last_grant, then update last_grant.
  - On a grant, latch the granted port's address, we and wdata into internal registers and go to ACCESS.
- ACCESS (1 cycle):
  - mem_en=1; mem_addr and mem_wdata come from the latched registers.
  - mem_we = latched d_we for port D, 0 for port I.
  - Load the counter with MEM_LAT and go to WAIT.
- WAIT:
  - Decrement the counter each cycle; all mem_* outputs = 0.
  - In the cycle the counter reaches 1, capture mem_rdata at the edge into the granted port's rdata register; writes capture nothing.
  - Go to RESP.
- RESP (1 cycle): assert the granted port's ack, then return to IDLE.
- Latency: request first high in cycle 0 (state IDLE) gives ack in cycle MEM_LAT+2 (cycle 3 at the default). Minimum spacing between acks is MEM_LAT+3 cycles.
- Width rules: rdata registers are DW wide and are never modified except by a read capture.
- Boundary conditions:
  - A requester that drops req before ack: the access still completes and the ack still pulses; it is not cancelled.
  - A req still high in the cycle after its ack is a new request.
  - The losing port of a conflict is granted at the next IDLE visit if it still requests; no starvation.
  - Changes to i_addr/d_addr after the grant do not affect the access in flight, because the request is latched.
  - Reset asserted mid-access aborts immediately: no ack, mem_en=0, rdata registers cleared.

Optional Feature:
- Macro ARB_STATS_EN.
- Defined:
  - Adds output conflicts [15:0], a count of IDLE cycles in which i_req and d_req were both 1 and a grant occurred.
  - The counter saturates at 16'hFFFF and resets to 0.
- Undefined: the port and counter do not exist; all other behaviour is identical.

Decomposition:
- Shared package mem_arb_pkg holds:
  - State encoding constants: ST_IDLE=2'd0, ST_ACCESS=2'd1, ST_WAIT=2'd2, ST_RESP=2'd3.
  - Port-select constants: SEL_I=1'b0, SEL_D=1'b1.
  - Default width constants.
- One natural sub-module, rr_arb2: a two-input round-robin grant with a last_grant register and an update enable. The FSM and counter stay in mem_port_arbiter.

Test Plan:
- Reset then single fetch: rst low 1 cycle; i_req=1, i_addr=32'h0000_0010, mem_rdata model returns 32'hDEAD_BEEF. Expect mem_en=1 with mem_addr=32'h10 and mem_we=0 in cycle 1, i_ack=1 with i_rdata=32'hDEAD_BEEF in cycle 3, d_ack never asserted.
- Data write: d_req=1, d_we=1, d_addr=32'h40, d_wdata=32'h1234_5678. Expect one mem_en cycle with mem_we=1 and matching addr/wdata, d_ack in cycle 3, d_rdata unchanged.
- Conflict and round-robin: both req held high from reset. Grant order must be I, D, I, D across 4 acks. With ARB_STATS_EN defined, conflicts=4.
- Latency parameter: MEM_LAT=3, single read. Expect ack in cycle 5 and exactly 1 mem_en pulse.
- Reset mid-access: assert rst during WAIT. Outputs go to 0 asynchronously with no ack. After release, a new i_req completes normally with I winning the first conflict.
- Early req drop: i_req drops in the ACCESS cycle. Expect i_ack still in cycle 3 and the FSM back in IDLE with busy=0 in cycle 4.
